muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions in the EX stage of the pipelined core. It accepts one operation at a time from the EX-stage decode (funct3 of an OP instruction with funct7 = 0000001) and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. While it runs it holds the pipeline through `stall`, then presents a one-cycle `done` with the result. ALU-decoded instructions never reach this block; EX selects `result` over the ALU output when `done` is high.

## Interface
- WIDTH, 32, operand/result width; also the iteration count.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  EX holds a valid M-extension instruction.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand.
- b  in  WIDTH  rs2 operand.
- flush  in  1  EX squash (branch/jump redirect); aborts the current operation.
- stall  out  1  hold IF/ID/EX; combinational.
- busy  out  1  registered; high in CALC and FIX.
- done  out  1  registered; one-cycle pulse, `result` valid.
- result  out  WIDTH  registered result; holds its value until the next DONE.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3, magnitudes |a| and |b|, and sign flags. Signed ops: MULH, MULHSU (a only), DIV, REM.
  - Clear the accumulator and counter, then go to CALC.
- Fast paths, IDLE direct to DONE, no CALC/FIX:
  - Divide by zero: DIV/DIVU quotient all-ones; REM/REMU result = a.
  - Signed overflow (DIV/REM, a = 0x8000_0000, b = 0xFFFF_FFFF): DIV → 0x8000_0000, REM → 0.
- CALC: one iteration per cycle; 5-bit counter 0..WIDTH-1; go to FIX after count WIDTH-1.
  - Multiply: 2·WIDTH-bit product register, shift-add on the multiplier LSB.
  - Divide: restoring division on magnitudes; WIDTH+1-bit partial remainder.
- FIX: apply signs.
  - Product is negated (two's complement, 2·WIDTH bits) if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of a.
  - Select the low half (MUL), high half (MULH*), quotient, or remainder into `result`. Go to DONE.
- DONE: done=1; go to IDLE. Start in DONE is ignored; it is still the retiring instruction.
- stall = (state==CALC) | (state==FIX) | (state==IDLE & start & ~flush). It is low in DONE, so the pipeline advances that cycle.
- flush in any state: next state IDLE. done stays 0 and result is unchanged. Flush takes priority over start and over counter completion.
- start while busy: ignored.
- Reset (rst_n=0 at a clock edge, in any state, including mid-operation): state IDLE, busy=0, done=0, result=0, counter=0. stall is then 0 unless start is high.

## Timing
- Normal latency: start sampled in IDLE at edge k. CALC occupies cycles k+1..k+WIDTH, FIX is cycle k+WIDTH+1, DONE is cycle k+WIDTH+2 (k+34 for WIDTH=32).
- stall is high in cycles k..k+33 and low in cycle k+34.
- Fast path: DONE in cycle k+1; stall is high only in cycle k.
- Back-to-back: the next start is accepted in IDLE at k+35. The minimum gap between done pulses is 35 cycles.
- Operands are sampled only at the accepting edge. a/b/funct3 may change afterwards.

## Test plan
- MUL a=7, b=0xFFFF_FFFD, start at cycle 0 → stall high cycles 0–33; done=1 only at cycle 34; result 0xFFFF_FFEB.
- MULH a=b=0x8000_0000 → result 0x4000_0000. MULHU a=b=0xFFFF_FFFF → 0xFFFF_FFFE. MULHSU a=0xFFFF_FFFF, b=2 → 0xFFFF_FFFF.
- DIV a=-7, b=2 → 0xFFFF_FFFD. REM same operands → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU a=5, b=0 → done at cycle 1, result 0xFFFF_FFFF. REM a=5, b=0 → 5. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000, done at cycle 1.
- Flush at cycle 10 of a DIV → busy=0 and stall=0 at cycle 11; no done; result keeps its prior value. A new MUL 3×4 started at cycle 11 → done at cycle 45, result 12.
- rst_n low at cycle 20 of a MUL → busy=0, done=0, result=0 from the next cycle; no done pulse follows.
- Start held high through DONE → no second operation launched.

Source files
------------

// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [CW-1:0]      count;
    logic [2:0]         op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               accept;
    logic               is_div;
    logic               a_signed;
    logic               b_signed;
    logic               in_sa;
    logic               in_sb;
    logic [WIDTH-1:0]   in_ma;
    logic [WIDTH-1:0]   in_mb;
    logic               div_zero;
    logic               ovf;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_df;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic [WIDTH-1:0]   fix_res;

    assign accept = (state == IDLE) & start & ~flush;
    assign stall  = (state == CALC) | (state == FIX) | accept;

    assign is_div   = funct3[2];
    assign a_signed = (funct3 == 3'b001) | (funct3 == 3'b010)
                    | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) | (funct3 == 3'b100)
                    | (funct3 == 3'b110);
    assign in_sa    = a_signed & a[WIDTH-1];
    assign in_sb    = b_signed & b[WIDTH-1];
    assign in_ma    = in_sa ? -a : a;
    assign in_mb    = in_sb ? -b : b;

    // Zero divisor and INT_MIN / -1 bypass the iteration entirely
    assign div_zero = (b == '0);
    assign ovf      = funct3[2] & ~funct3[0]
                    & (a == {1'b1, {(WIDTH-1){1'b0}}})
                    & (b == {WIDTH{1'b1}});
    assign fast     = is_div & (div_zero | ovf);

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = funct3[1] ? a : {WIDTH{1'b1}};
        else
            fast_res = funct3[1] ? '0 : a;
    end

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_nx  = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                            : {1'b0, acc[2*WIDTH-1:1]};
    assign div_sh  = {rem, acc[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, opnd};

    assign prod = (sign_a ^ sign_b) ? -acc : acc;
    assign quo  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rmd  = sign_a ? -rem : rem;

    always_comb begin
        fix_res = rmd;
        unique case (op)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rmd;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = fast ? DONE : CALC;
            CALC: if (count == CW'(WIDTH-1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == CALC) | (state_nx == FIX);
            done  <= (state_nx == DONE);
            if (accept)
                count <= '0;
            else if (state == CALC && !flush)
                count <= count + CW'(1);
            if (!flush) begin
                if (accept && fast)
                    result <= fast_res;
                if (state == FIX)
                    result <= fix_res;
            end
        end
    end

    // Operand and iteration registers need no reset: loaded on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            op     <= funct3;
            sign_a <= in_sa;
            sign_b <= in_sb;
            opnd   <= is_div ? in_mb : in_ma;
            acc    <= {{WIDTH{1'b0}}, (is_div ? in_ma : in_mb)};
            rem    <= '0;
        end else if (state == CALC) begin
            if (op[2]) begin
                acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_df[WIDTH]};
                rem <= div_df[WIDTH] ? div_sh[WIDTH-1:0]
                                     : div_df[WIDTH-1:0];
            end else begin
                acc <= mul_nx;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and scoreboard bench for muldiv_seq.
// Expected results come from a 64-bit arithmetic reference model.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int passed = 0;
    int failed = 0;
    int total = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .funct3(funct3),
        .a(a),
        .b(b),
        .flush(flush),
        .stall(stall),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (done) done_cnt++;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] f,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic [W-1:0] r;
        logic ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r = '0;
        case (f)
            3'b000: begin p = 64'(ux * uy); r = p[31:0]; end
            3'b001: begin p = 64'(sx * sy); r = p[63:32]; end
            3'b010: begin p = 64'(sx * uy); r = p[63:32]; end
            3'b011: begin p = 64'(ux * uy); r = p[63:32]; end
            3'b100: begin
                if (y == 0) r = '1;
                else if (ov) r = x;
                else begin p = 64'(sx / sy); r = p[31:0]; end
            end
            3'b101: r = (y == 0) ? '1 : x / y;
            3'b110: begin
                if (y == 0) r = x;
                else if (ov) r = '0;
                else begin p = 64'(sx % sy); r = p[31:0]; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000
                                     && y == 32'hFFFF_FFFF));
    endfunction

    // Call in the second half of an IDLE cycle; returns in the next IDLE cycle
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit hold = 1'b0);
        int lat, c;
        bit ok, seen;
        logic [W-1:0] exp;
        lat = is_fast(f, x, y) ? 1 : 34;
        exp_q.push_back(ref_op(f, x, y));
        start = 1'b1;
        funct3 = f;
        a = x;
        b = y;
        #1 check({tag, " stall_accept"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = $urandom;
        b = $urandom;
        funct3 = 3'($urandom);
        ok = 1'b1;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (done) begin
                seen = 1'b1;
                if (stall || busy) ok = 1'b0;
            end else if (!(stall && busy)) begin
                ok = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(c), 32'(lat));
        check({tag, " stall_busy"}, 32'(ok), 32'd1);
        exp = exp_q.pop_front();
        check({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        if (hold) begin
            start = 1'b0;
            @(negedge clk);
            check({tag, " no_relaunch"}, {30'b0, busy, done}, 32'd0);
            @(negedge clk);
            check({tag, " still_idle"}, {30'b0, busy, done}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int d0;
        logic [W-1:0] prior;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD);
        run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000);
        run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2);
        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7);
        run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0);
        run_op("REM 5%0", 3'b110, 32'd5, 32'd0);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("REMU 100%7", 3'b111, 32'd100, 32'd7);

        // Flush a DIV in cycle 10; no done, result keeps REMU value
        prior = result;
        d0 = done_cnt;
        start = 1'b1;
        funct3 = 3'b100;
        a = 32'hFFFF_FF9C;
        b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(busy), 32'd0);
        check("flush stall", 32'(stall), 32'd0);
        check("flush result", result, prior);
        check("flush no_done", 32'(done_cnt - d0), 32'd0);
        run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4);

        // Reset in cycle 20 of a MUL
        d0 = done_cnt;
        start = 1'b1;
        funct3 = 3'b000;
        a = 32'd5;
        b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        repeat (40) @(negedge clk);
        check("midrst no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst result_hold", result, 32'd0);
        @(posedge clk);
        #1;

        run_op("MUL hold start", 3'b000, 32'd9, 32'd9, 1'b1);

        for (int i = 0; i < 4; i++)
            run_op("random", 3'($urandom), $urandom,
                   (i == 1) ? 32'($urandom_range(1, 20)) : $urandom);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
